inst_loop_ctrl: RTL and testbench



---
 rtl/inst_loop_ctrl_pkg.sv | 27 ++
 rtl/inst_loop_ctrl_if.sv | 31 +++
 rtl/inst_loop_ctrl_loop_level_cnt.sv | 40 ++++
 rtl/inst_loop_ctrl.sv | 144 ++++++++++++++
 tb/tb_inst_loop_ctrl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_loop_ctrl_pkg.sv
// inst_loop_ctrl_pkg: shared loop-mode/state types and CSR field layout for the loop controller
package inst_loop_ctrl_pkg;

    typedef enum logic [1:0] {
        LOOP_SINGLE = 2'd0,
        LOOP_DOUBLE = 2'd1,
        LOOP_TRIPLE = 2'd2
    } loop_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam int NumLoopsDef = 3;
    // CSR loop fields sit at bit offsets 0/8/16, one byte per level
    localparam int FieldStride = 8;

    // Number of participating levels; modes 2 and 3 both select all three
    function automatic int active_levels(input logic [1:0] mode, input int num);
        int lvl;
        lvl = (mode == LOOP_SINGLE) ? 1 : (mode == LOOP_DOUBLE) ? 2 : 3;
        return (lvl > num) ? num : lvl;
    endfunction

endpackage

// File: rtl/inst_loop_ctrl_if.sv
// inst_loop_ctrl_if: CSR-side control/config and instruction-fetch outputs of the loop controller
interface inst_loop_ctrl_if
    import inst_loop_ctrl_pkg::*;
#(
    parameter int InstAddrWidth = FieldStride,
    parameter int LoopCntWidth  = FieldStride,
    parameter int NumLoops      = NumLoopsDef
);
    logic                              start;
    logic                              clr;
    logic                              stall;
    logic [1:0]                        loop_mode;
    logic [NumLoops*InstAddrWidth-1:0] jump_addr;
    logic [NumLoops*InstAddrWidth-1:0] end_addr;
    logic [NumLoops*LoopCntWidth-1:0]  loop_count;
    logic [InstAddrWidth-1:0]          pc;
    logic                              pc_valid;
    logic                              busy;
    logic                              done;
    logic [31:0]                       perf_count;

    modport master (
        output start, clr, stall, loop_mode, jump_addr, end_addr, loop_count,
        input  pc, pc_valid, busy, done, perf_count
    );

    modport slave (
        input  start, clr, stall, loop_mode, jump_addr, end_addr, loop_count,
        output pc, pc_valid, busy, done, perf_count
    );
endinterface

// File: rtl/inst_loop_ctrl_loop_level_cnt.sv
// loop_level_cnt: one nesting level -- iteration counter, shadowed limit/end address, end-hit and exhausted flags
module loop_level_cnt #(
    parameter int InstAddrWidth = 8,
    parameter int LoopCntWidth  = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     load,
    input  logic                     inc,
    input  logic                     clr,
    input  logic [InstAddrWidth-1:0] end_in,
    input  logic [LoopCntWidth-1:0]  count_in,
    input  logic [InstAddrWidth-1:0] pc,
    output logic                     hit,
    output logic                     exhausted
);
    logic [LoopCntWidth-1:0]  cnt;
    logic [LoopCntWidth-1:0]  last;
    logic [InstAddrWidth-1:0] end_sh;

    assign hit       = end_sh == pc;
    assign exhausted = cnt == last;

    // Shadow the level config on start (count 0 runs once) and step the iteration counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt    <= '0;
            last   <= '0;
            end_sh <= '0;
        end else if (load) begin
            end_sh <= end_in;
            last   <= (count_in == '0) ? '0 : count_in - 1'b1;
            cnt    <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/inst_loop_ctrl.sv
// inst_loop_ctrl: PC sequencer with up to three nested zero-overhead hardware loops
// Optional build macro INST_LOOP_CTRL_PERF_CNT_EN adds a saturating issued-instruction counter.
module inst_loop_ctrl
    import inst_loop_ctrl_pkg::*;
#(
    parameter int InstAddrWidth = FieldStride,
    parameter int LoopCntWidth  = FieldStride,
    parameter int NumLoops      = NumLoopsDef
) (
    input logic          clk_i,
    input logic          rst_ni,
    inst_loop_ctrl_if.slave bus
);
    state_e                   state;
    logic [InstAddrWidth-1:0] pc;
    logic                     pc_valid;
    logic                     busy;
    logic                     done;
    logic [InstAddrWidth-1:0] jump_sh [NumLoops];
    logic [1:0]               mode_sh;
    logic [NumLoops-1:0]      hit;
    logic [NumLoops-1:0]      exh;
    logic [NumLoops-1:0]      inc;
    logic [NumLoops-1:0]      lvl_clr;
    logic [InstAddrWidth-1:0] jump_pc;
    logic                     found;
    logic                     fin;
    logic                     adv;
    logic                     load;
    int                       act;

    assign bus.pc       = pc;
    assign bus.pc_valid = pc_valid;
    assign bus.busy     = busy;
    assign bus.done     = done;

    assign adv  = state == RUN && !bus.stall && !bus.clr;
    assign load = state == IDLE && bus.start && !bus.clr;
    assign act  = active_levels(mode_sh, NumLoops);

    for (genvar g = 0; g < NumLoops; g++) begin : g_lvl
        loop_level_cnt #(
            .InstAddrWidth(InstAddrWidth),
            .LoopCntWidth (LoopCntWidth)
        ) u_lvl (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .load     (load),
            .inc      (inc[g]),
            .clr      (lvl_clr[g]),
            .end_in   (bus.end_addr[g*InstAddrWidth +: InstAddrWidth]),
            .count_in (bus.loop_count[g*LoopCntWidth +: LoopCntWidth]),
            .pc       (pc),
            .hit      (hit[g]),
            .exhausted(exh[g])
        );
    end

    // Innermost-first scan: first unexhausted level ending here jumps, exhausted ones rewind on the way out
    always_comb begin
        found   = 1'b0;
        inc     = '0;
        lvl_clr = {NumLoops{bus.clr}};
        jump_pc = pc;
        for (int i = NumLoops - 1; i >= 0; i--) begin
            if (adv && !found && i < act && hit[i]) begin
                if (!exh[i]) begin
                    found   = 1'b1;
                    inc[i]  = 1'b1;
                    jump_pc = jump_sh[i];
                end else begin
                    lvl_clr[i] = 1'b1;
                end
            end
        end
        fin = adv && !found && hit[0] && exh[0];
    end

    // Sequencing FSM with registered fetch/status outputs; clear beats start
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            pc       <= '0;
            pc_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mode_sh  <= '0;
            for (int i = 0; i < NumLoops; i++) jump_sh[i] <= '0;
        end else if (bus.clr) begin
            state    <= IDLE;
            pc       <= '0;
            pc_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (bus.start) begin
                        state    <= RUN;
                        pc       <= bus.jump_addr[0 +: InstAddrWidth];
                        pc_valid <= 1'b1;
                        busy     <= 1'b1;
                        mode_sh  <= bus.loop_mode;
                        for (int i = 0; i < NumLoops; i++)
                            jump_sh[i] <= bus.jump_addr[i*InstAddrWidth +: InstAddrWidth];
                    end
                end
                RUN: begin
                    if (!bus.stall) begin
                        if (fin) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            pc_valid <= 1'b0;
                            busy     <= 1'b0;
                        end else begin
                            pc <= found ? jump_pc : pc + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef INST_LOOP_CTRL_PERF_CNT_EN
    logic [31:0] perf;

    assign bus.perf_count = perf;

    // Count advancing RUN cycles, saturating; value survives into IDLE for readout
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) perf <= '0;
        else if (bus.clr || load) perf <= '0;
        else if (state == RUN && !bus.stall && perf != 32'hFFFF_FFFF) perf <= perf + 1'b1;
    end
`else
    assign bus.perf_count = '0;
`endif
endmodule

// File: tb/tb_inst_loop_ctrl.sv
// tb_inst_loop_ctrl: directed bench with a fetch-sequence model of the loop rules
module tb_inst_loop_ctrl;
    logic clk;
    logic rst_n;

    inst_loop_ctrl_if bus ();

    inst_loop_ctrl dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int          fetches = 0;
    int          dones = 0;
    int          seq[$];
    int          last_seq[$];
    logic [7:0]  m_pc = '0;
    bit          m_run = 0;
    bit          m_done = 0;
    longint      m_perf = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Expected fetch order from the configuration, walked address by address
    function automatic void build();
        int lvls;
        int cnt[3];
        int lim[3];
        int jmp[3];
        int ed[3];
        int pc;
        bit jumped;
        bit ex0;
        seq.delete();
        lvls = (bus.loop_mode == 2'd0) ? 1 : (bus.loop_mode == 2'd1) ? 2 : 3;
        for (int i = 0; i < 3; i++) begin
            cnt[i] = 0;
            jmp[i] = int'(bus.jump_addr[i*8 +: 8]);
            ed[i]  = int'(bus.end_addr[i*8 +: 8]);
            lim[i] = (bus.loop_count[i*8 +: 8] == 8'd0) ? 1 : int'(bus.loop_count[i*8 +: 8]);
        end
        pc = jmp[0];
        for (int n = 0; n < 4096; n++) begin
            seq.push_back(pc);
            jumped = 0;
            ex0 = (cnt[0] == lim[0] - 1);
            for (int i = lvls - 1; i >= 0; i--) begin
                if (!jumped && ed[i] == pc) begin
                    if (cnt[i] != lim[i] - 1) begin
                        pc = jmp[i];
                        cnt[i]++;
                        jumped = 1;
                    end else begin
                        cnt[i] = 0;
                    end
                end
            end
            if (!jumped && ed[0] == pc && ex0) break;
            if (!jumped) pc = (pc + 1) % 256;
        end
        last_seq = seq;
    endfunction

    // Cycle model: IDLE/RUN/DONE as flags, PC taken from the precomputed fetch list
    initial forever begin
        @(posedge clk);
        if (!rst_n || bus.clr) begin
            m_run = 0;
            m_done = 0;
            m_pc = '0;
            m_perf = 0;
            seq.delete();
        end else if (m_run) begin
            if (!bus.stall) begin
                if (m_perf != 64'hFFFF_FFFF) m_perf++;
                void'(seq.pop_front());
                if (seq.size() == 0) begin
                    m_run = 0;
                    m_done = 1;
                end else begin
                    m_pc = 8'(seq[0]);
                end
            end
        end else if (m_done) begin
            m_done = 0;
        end else if (bus.start) begin
            build();
            m_run = 1;
            m_pc = 8'(seq[0]);
            m_perf = 0;
        end
    end

    // Compare every cycle against the model; in reset everything must be zero
    initial forever begin
        @(negedge clk);
        chk("pc", bus.pc, rst_n ? m_pc : 0);
        chk("pc_valid", bus.pc_valid, rst_n ? m_run : 0);
        chk("busy", bus.busy, rst_n ? m_run : 0);
        chk("done", bus.done, rst_n ? m_done : 0);
`ifdef INST_LOOP_CTRL_PERF_CNT_EN
        chk("perf", bus.perf_count, rst_n ? m_perf : 0);
`else
        chk("perf_tied", bus.perf_count, 0);
`endif
        if (rst_n && bus.pc_valid) fetches++;
        if (rst_n && bus.done) dones++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int mode, input int j0, input int j1, input int j2,
                       input int e0, input int e1, input int e2,
                       input int c0, input int c1, input int c2);
        bus.loop_mode  = 2'(mode);
        bus.jump_addr  = {8'(j2), 8'(j1), 8'(j0)};
        bus.end_addr   = {8'(e2), 8'(e1), 8'(e0)};
        bus.loop_count = {8'(c2), 8'(c1), 8'(c0)};
    endtask

    task automatic run(input string nm, input int exp_f, input int spc, input int slen, input bit poke);
        bit stalled = 0;
        bit seen = 0;
        fetches = 0;
        dones = 0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            if (poke && k == 2) begin
                bus.start      = 1'b1;
                bus.loop_mode  = 2'($urandom);
                bus.jump_addr  = 24'($urandom);
                bus.end_addr   = 24'($urandom);
                bus.loop_count = 24'($urandom);
            end
            if (poke && k == 3) bus.start = 1'b0;
            if (slen > 0 && !stalled && bus.pc_valid && bus.pc == 8'(spc)) begin
                bus.stall = 1'b1;
                repeat (slen) step();
                bus.stall = 1'b0;
                stalled = 1;
            end
            step();
            seen = bus.done;
        end
        chk({nm, "_done_seen"}, seen, 1);
        step();
        step();
        chk({nm, "_fetches"}, fetches, exp_f);
        chk({nm, "_done_pulses"}, dones, 1);
        chk({nm, "_busy_after"}, bus.busy, 0);
    endtask

    int single_exp[9] = '{2, 3, 4, 2, 3, 4, 2, 3, 4};
    int nest_exp[16]  = '{0, 1, 2, 3, 2, 3, 4, 5, 0, 1, 2, 3, 2, 3, 4, 5};

    initial begin
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.clr    = 1'b0;
        bus.stall  = 1'b0;
        cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        chk("rst_pc", bus.pc, 0);
        chk("rst_valid", bus.pc_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);

        cfg(0, 2, 0, 0, 4, 0, 0, 3, 0, 0);
        run("single", 9, 0, 0, 1);
        chk("single_len", last_seq.size(), 9);
        for (int i = 0; i < 9; i++)
            chk("single_seq", (i < last_seq.size()) ? last_seq[i] : -1, single_exp[i]);

        cfg(1, 0, 2, 0, 5, 3, 0, 2, 2, 0);
        run("nested", 16, 0, 0, 1);
        chk("nested_len", last_seq.size(), 16);
        for (int i = 0; i < 16; i++)
            chk("nested_seq", (i < last_seq.size()) ? last_seq[i] : -1, nest_exp[i]);

        cfg(2, 0, 3, 5, 6, 6, 6, 2, 2, 2);
        run("shared", 30, 0, 0, 0);
        chk("shared_len", last_seq.size(), 30);
        chk("shared_last", last_seq[last_seq.size()-1], 6);

        cfg(0, 2, 0, 0, 4, 0, 0, 3, 0, 0);
        run("stall", 12, 4, 3, 0);
`ifdef INST_LOOP_CTRL_PERF_CNT_EN
        chk("stall_perf", bus.perf_count, 9);
`endif

        cfg(0, 2, 0, 0, 4, 0, 0, 3, 0, 0);
        dones = 0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 100 && !(bus.pc_valid && bus.pc == 8'd3); k++) step();
        chk("clr_reach_pc", bus.pc, 3);
        bus.clr = 1'b1;
        bus.start = 1'b1;
        step();
        bus.clr = 1'b0;
        bus.start = 1'b0;
        chk("clr_pc", bus.pc, 0);
        chk("clr_valid", bus.pc_valid, 0);
        chk("clr_busy", bus.busy, 0);
        repeat (5) step();
        chk("clr_no_done", dones, 0);
        run("after_clr", 9, 0, 0, 0);

        cfg(3, 0, 3, 5, 6, 6, 6, 0, 2, 2);
        run("mode3_cnt0", 15, 0, 0, 0);
        cfg(2, 0, 3, 5, 6, 6, 6, 0, 2, 2);
        run("mode2_cnt0", 15, 0, 0, 0);

        cfg(0, 2, 0, 0, 4, 0, 0, 3, 0, 0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (3) step();
        chk("arst_pre_busy", bus.busy, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_pc", bus.pc, 0);
        chk("arst_valid", bus.pc_valid, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_done", bus.done, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) step();
        chk("arst_idle_busy", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
